mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address ports.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port if_req_i  input  1  instruction-fetch request, held until if_done_o.
REQ-005 SHALL have port if_addr_i  input  ADDR_W  fetch byte address.
REQ-006 SHALL have port if_data_o  output  32  fetched word, valid while if_done_o=1.
REQ-007 SHALL have port if_done_o  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port mem_req_i  input  1  load/store request, held until mem_done_o.
REQ-009 SHALL have port mem_we_i  input  1  1=store, 0=load.
REQ-010 SHALL have port mem_addr_i  input  ADDR_W  load/store byte address.
REQ-011 SHALL have port mem_len_i  input  2  access size: 0=1 byte, 1=2 bytes, 2 or 3=4 bytes.
REQ-012 SHALL have port mem_wdata_i  input  32  store data, low bytes used.
REQ-013 SHALL have port mem_rdata_o  output  32  load data, zero-extended, valid while mem_done_o=1.
REQ-014 SHALL have port mem_done_o  output  1  one-cycle load/store completion pulse.
REQ-015 SHALL have port ram_addr_o  output  ADDR_W  byte-wide RAM address.
REQ-016 SHALL have port ram_wr_o  output  1  RAM write strobe.
REQ-017 SHALL have port ram_dout_o  output  8  RAM write byte.
REQ-018 SHALL have port ram_din_i  input  8  RAM read byte, valid one cycle after its address.
REQ-019 SHALL have port busy_o  output  1  1 whenever state is not IDLE.

Function
REQ-020 SHALL implement states IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
REQ-021 In IDLE, SHALL grant on a sampled request: MEM over IF, except IF wins when both pending and the previous grant was MEM.
REQ-022 SHALL latch address, we, N (byte count from len; IF always N=4) and wdata at grant; requester inputs ignored until DONE.
REQ-023 Read states: counter c runs 0..N; for c<N drive ram_addr_o=base+c (wrap modulo 2^ADDR_W), ram_wr_o=0; at the edge ending cycle c>=1 capture ram_din_i into byte c-1 (little-endian).
REQ-024 Write state: counter c runs 0..N-1; drive ram_addr_o=base+c, ram_wr_o=1, ram_dout_o=wdata byte c.
REQ-025 After last read capture or last write byte, SHALL enter DONE for exactly one cycle: relevant done_o=1, data output valid, ram_wr_o=0, no new grant; then IDLE.
REQ-026 Latency from grant edge to done pulse: read N+2 cycles, write N+1 cycles.
REQ-027 Outside active RAM cycles, ram_addr_o=0, ram_dout_o=0, ram_wr_o=0.
REQ-028 if_data_o/mem_rdata_o SHALL hold last captured value after done; unused upper bytes of loads = 0.
REQ-029 Requester SHALL deassert req in the cycle after done; a req still high in the first IDLE cycle is a new request.
REQ-030 if_done_o and mem_done_o SHALL never be 1 in the same cycle.

Reset
REQ-031 On rising edge with rst=0: state IDLE, counter 0, last-grant=IF, all outputs 0, regardless of transaction in progress.
REQ-032 A transaction interrupted by reset SHALL be abandoned with no done pulse; no ram_wr_o after the reset edge.

Verification
REQ-033 IF fetch addr 0x100, RAM bytes 13,05,10,00 -> ram_addr 0x100..0x103, if_done 6 cycles after grant, if_data_o=0x00100513.
REQ-034 Store len=1 addr 0x2000 wdata 0xDEADBEEF -> ram_wr=1 two cycles, bytes EF@0x2000, BE@0x2001, mem_done 3 cycles after grant.
REQ-035 Load len=0 addr 0x30, RAM byte 0x80 -> mem_rdata_o=0x00000080, done 3 cycles after grant.
REQ-036 if_req and mem_req held together continuously -> grants alternate MEM, IF, MEM, IF; no two done pulses coincide.
REQ-037 rst=0 during cycle c=2 of word store -> ram_wr_o=0 and busy_o=0 next cycle, no mem_done; next request served normally.
REQ-038 Word load at addr 0xFFFFFFFE -> ram_addr 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction-fetch and load/store requests onto a byte-wide RAM
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [1:0]        mem_len_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o,
   output logic [7:0]        ram_dout_o,
   input  logic [7:0]        ram_din_i,
   output logic              busy_o
);
   typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
   state_t state_q, state_d;
   logic [2:0] c_q, c_d, n_q, n_d;
   logic [ADDR_W-1:0] base_q, base_d, ram_addr_q, ram_addr_d;
   logic [31:0] wdata_q, wdata_d, if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
   logic [7:0] ram_dout_q, ram_dout_d;
   logic ram_wr_q, ram_wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;
   logic busy_q, busy_d, last_mem_q, last_mem_d;
   logic [1:0] rb, wb;
   assign rb = 2'(c_q - 3'd1);
   assign wb = 2'(c_q + 3'd1);
   // next-state and registered-output computation; RAM outputs default to 0 outside active cycles
   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      n_d         = n_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      last_mem_d  = last_mem_q;
      ram_addr_d  = '0;
      ram_dout_d  = '0;
      ram_wr_d    = 1'b0;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_req_i && !(if_req_i && last_mem_q)) begin
               state_d    = mem_we_i ? MEM_WR : MEM_RD;
               base_d     = mem_addr_i;
               n_d        = (mem_len_i == 2'd0) ? 3'd1 : (mem_len_i == 2'd1) ? 3'd2 : 3'd4;
               wdata_d    = mem_wdata_i;
               last_mem_d = 1'b1;
               c_d        = '0;
               ram_addr_d = mem_addr_i;
               ram_wr_d   = mem_we_i;
               ram_dout_d = mem_we_i ? mem_wdata_i[7:0] : 8'h00;
               if (!mem_we_i) mem_rdata_d = '0;
            end else if (if_req_i) begin
               state_d    = IF_RD;
               base_d     = if_addr_i;
               n_d        = 3'd4;
               last_mem_d = 1'b0;
               c_d        = '0;
               ram_addr_d = if_addr_i;
               if_data_d  = '0;
            end
         end
         IF_RD, MEM_RD: begin
            c_d = c_q + 3'd1;
            if (c_q != 3'd0) begin
               if (state_q == IF_RD) if_data_d[{rb, 3'b000} +: 8] = ram_din_i;
               else mem_rdata_d[{rb, 3'b000} +: 8] = ram_din_i;
            end
            if (c_q + 3'd1 < n_q) ram_addr_d = base_q + ADDR_W'(c_q + 3'd1);
            if (c_q == n_q) begin
               state_d    = DONE;
               c_d        = '0;
               if_done_d  = (state_q == IF_RD);
               mem_done_d = (state_q == MEM_RD);
            end
         end
         MEM_WR: begin
            if (c_q + 3'd1 < n_q) begin
               c_d        = c_q + 3'd1;
               ram_addr_d = base_q + ADDR_W'(c_q + 3'd1);
               ram_wr_d   = 1'b1;
               ram_dout_d = wdata_q[{wb, 3'b000} +: 8];
            end else begin
               state_d    = DONE;
               c_d        = '0;
               mem_done_d = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end
   // state and output registers; reset abandons any transaction in progress
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         c_q         <= '0;
         n_q         <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         last_mem_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         n_q         <= n_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         last_mem_q  <= last_mem_d;
         ram_addr_q  <= ram_addr_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         busy_q      <= busy_d;
      end
   end
   assign if_data_o   = if_data_q;
   assign if_done_o   = if_done_q;
   assign mem_rdata_o = mem_rdata_q;
   assign mem_done_o  = mem_done_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_wr_o    = ram_wr_q;
   assign ram_dout_o  = ram_dout_q;
   assign busy_o      = busy_q;
endmodule
